// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Breakout ball position, bounce and miss logic advanced once per game tick
module ball_motion #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 64,
    parameter int PADDLE_Y  = 448,
    parameter int STEP      = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       moving,
    output logic       life_lost
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVING,
        S_LOST
    } state_t;

    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic signed [11:0] SIZE_S   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PW_S     = 12'(PADDLE_W);
    localparam logic signed [11:0] PY_S     = 12'(PADDLE_Y);
    localparam logic signed [11:0] VA_S     = 12'(V_ACTIVE);
    localparam logic signed [11:0] X_MAX_S  = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]         X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]         Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]         Y_REST   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]         X_OFFSET = 10'(PADDLE_W / 2 - BALL_SIZE / 2);

    state_t state, state_nxt;
    logic [9:0] x_nxt, y_nxt;
    logic dx_right, dx_right_nxt;
    logic dy_down, dy_down_nxt;
    logic brick_pending, brick_pending_nxt;

    logic dy_eff;
    logic signed [11:0] bx, by, px, nx, ny;

    // Signed intermediates leave headroom for nx/ny going below 0 or past the right edge.
    assign bx     = $signed({2'b00, ball_x});
    assign by     = $signed({2'b00, ball_y});
    assign px     = $signed({2'b00, paddle_x});
    assign dy_eff = (brick_pending || brick_hit) ? ~dy_down : dy_down;
    assign nx     = bx + (dx_right ? STEP_S : -STEP_S);
    assign ny     = by + (dy_eff ? STEP_S : -STEP_S);

    always_comb begin
        state_nxt         = state;
        x_nxt             = ball_x;
        y_nxt             = ball_y;
        dx_right_nxt      = dx_right;
        dy_down_nxt       = dy_down;
        brick_pending_nxt = brick_pending;
        case (state)
            S_IDLE: begin
                x_nxt             = paddle_x + X_OFFSET;
                y_nxt             = Y_REST;
                brick_pending_nxt = 1'b0;
                if (launch) begin
                    state_nxt    = S_MOVING;
                    dx_right_nxt = 1'b1;
                    dy_down_nxt  = 1'b0;
                end
            end
            S_MOVING: begin
                if (tick) begin
                    brick_pending_nxt = 1'b0;
                    dy_down_nxt       = dy_eff;
                    if (nx <= 12'sd0) begin
                        x_nxt        = 10'd0;
                        dx_right_nxt = 1'b1;
                    end else if (nx >= X_MAX_S) begin
                        x_nxt        = X_MAX;
                        dx_right_nxt = 1'b0;
                    end else begin
                        x_nxt = nx[9:0];
                    end
                    if (ny <= 12'sd0) begin
                        y_nxt       = 10'd0;
                        dy_down_nxt = 1'b1;
                    end else if (dy_eff && (by + SIZE_S <= PY_S) && (ny + SIZE_S >= PY_S)
                                 && (nx + SIZE_S > px) && (nx < px + PW_S)) begin
                        y_nxt       = Y_REST;
                        dy_down_nxt = 1'b0;
                    end else if (ny + SIZE_S >= VA_S) begin
                        y_nxt     = Y_MAX;
                        state_nxt = S_LOST;
                    end else begin
                        y_nxt = ny[9:0];
                    end
                end else if (brick_hit) begin
                    brick_pending_nxt = 1'b1;
                end
            end
            S_LOST: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            ball_x        <= X_OFFSET;
            ball_y        <= Y_REST;
            dx_right      <= 1'b1;
            dy_down       <= 1'b0;
            brick_pending <= 1'b0;
            moving        <= 1'b0;
            life_lost     <= 1'b0;
        end else begin
            state         <= state_nxt;
            ball_x        <= x_nxt;
            ball_y        <= y_nxt;
            dx_right      <= dx_right_nxt;
            dy_down       <= dy_down_nxt;
            brick_pending <= brick_pending_nxt;
            moving        <= (state_nxt == S_MOVING);
            life_lost     <= (state_nxt == S_LOST);
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - randomized and directed checks of ball_motion against a behavioural model
module tb_ball_motion;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       launch = 1'b0;
    logic       brick_hit = 1'b0;
    logic [9:0] paddle_x = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       moving, life_lost;

    int checks = 0;
    int failures = 0;

    // Model state: 0 idle, 1 moving, 2 lost; directions are +1/-1.
    int  m_x, m_y, m_dx, m_dy, m_st;
    bit  m_pend;

    ball_motion dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .launch    (launch),
        .paddle_x  (paddle_x),
        .brick_hit (brick_hit),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .moving    (moving),
        .life_lost (life_lost)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit t, input bit l, input bit bh, input int px);
        int nx, ny, d;
        if (r) begin
            m_st = 0; m_x = 28; m_y = 440; m_dx = 1; m_dy = -1; m_pend = 0;
        end else if (m_st == 0) begin
            m_x = (px + 28) % 1024;
            m_y = 440;
            m_pend = 0;
            if (l) begin
                m_st = 1; m_dx = 1; m_dy = -1;
            end
        end else if (m_st == 1) begin
            if (t) begin
                d = (m_pend || bh) ? -m_dy : m_dy;
                m_pend = 0;
                nx = m_x + 2 * m_dx;
                ny = m_y + 2 * d;
                if (ny <= 0) begin
                    m_y = 0; d = 1;
                end else if (d == 1 && m_y + 8 <= 448 && ny + 8 >= 448 && nx + 8 > px && nx < px + 64) begin
                    m_y = 440; d = -1;
                end else if (ny + 8 >= 480) begin
                    m_y = 472; m_st = 2;
                end else begin
                    m_y = ny;
                end
                m_dy = d;
                if (nx <= 0) begin
                    m_x = 0; m_dx = 1;
                end else if (nx >= 632) begin
                    m_x = 632; m_dx = -1;
                end else begin
                    m_x = nx;
                end
            end else if (bh) begin
                m_pend = 1;
            end
        end else begin
            m_st = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit l, input bit bh, input int px);
        reset = r; tick = t; launch = l; brick_hit = bh; paddle_x = px[9:0];
        model(r, t, l, bh, px);
        @(posedge clock);
        #1;
        check("ball_x", 32'(ball_x), 32'(m_x));
        check("ball_y", 32'(ball_y), 32'(m_y));
        check("moving", 32'(moving), 32'(m_st == 1));
        check("life_lost", 32'(life_lost), 32'(m_st == 2));
    endtask

    initial begin
        int px, seen, t, l, bh, r;

        cyc(1, 0, 0, 0, 100);
        cyc(1, 1, 0, 0, 100);
        check("reset_x", 32'(ball_x), 32'd28);
        check("reset_y", 32'(ball_y), 32'd440);
        cyc(0, 1, 0, 0, 100);
        cyc(0, 1, 0, 0, 100);
        check("idle_x", 32'(ball_x), 32'd128);
        check("idle_y", 32'(ball_y), 32'd440);
        check("idle_moving", 32'(moving), 32'd0);

        cyc(0, 0, 1, 0, 100);
        check("launch_x", 32'(ball_x), 32'd128);
        check("launch_moving", 32'(moving), 32'd1);
        cyc(0, 1, 0, 0, 100);
        check("fly1", {ball_x, ball_y}, {10'd130, 10'd438});
        cyc(0, 1, 0, 0, 100);
        check("fly2", {ball_x, ball_y}, {10'd132, 10'd436});
        cyc(0, 1, 0, 0, 100);
        check("fly3", {ball_x, ball_y}, {10'd134, 10'd434});

        cyc(0, 0, 0, 1, 100);
        cyc(0, 0, 0, 0, 100);
        cyc(0, 0, 0, 1, 100);
        cyc(0, 1, 0, 0, 100);
        check("brick_once", 32'(ball_y), 32'd436);
        cyc(0, 1, 0, 0, 100);
        check("brick_down", 32'(ball_y), 32'd438);

        cyc(0, 0, 0, 1, 100);
        cyc(1, 0, 0, 0, 100);
        check("midreset_x", 32'(ball_x), 32'd28);
        check("midreset_moving", 32'(moving), 32'd0);
        cyc(0, 0, 1, 0, 100);
        cyc(0, 1, 0, 0, 100);
        check("pend_cleared_y", 32'(ball_y), 32'd438);

        cyc(1, 0, 0, 0, 575);
        cyc(0, 0, 0, 0, 575);
        check("odd_idle_x", 32'(ball_x), 32'd603);
        cyc(0, 0, 1, 0, 575);
        for (int k = 0; k < 14; k++) cyc(0, 1, 0, 0, 575);
        check("near_wall_x", 32'(ball_x), 32'd631);
        cyc(0, 1, 0, 0, 575);
        check("right_wall_x", 32'(ball_x), 32'd632);
        cyc(0, 1, 0, 0, 575);
        check("right_back_x", 32'(ball_x), 32'd630);

        cyc(0, 0, 0, 1, 0);
        seen = 0;
        for (int k = 0; k < 80 && !seen; k++) begin
            cyc(0, 1, 0, 0, 0);
            if (life_lost) seen = 1;
            else cyc(0, 0, 0, 0, 0);
        end
        check("miss_seen", 32'(seen), 32'd1);
        check("miss_y", 32'(ball_y), 32'd472);
        cyc(0, 1, 0, 0, 0);
        check("lost_one_cycle", 32'(life_lost), 32'd0);
        check("lost_idle", 32'(moving), 32'd0);
        cyc(0, 0, 0, 0, 40);
        check("snap_x", 32'(ball_x), 32'd68);
        check("snap_y", 32'(ball_y), 32'd440);

        for (int i = 0; i < 20000; i++) begin
            r  = ($urandom_range(2999) == 0);
            t  = ($urandom_range(3) == 0);
            l  = (m_st == 0) ? ($urandom_range(7) == 0) : int'($urandom_range(1));
            bh = ($urandom_range(39) == 0);
            if (m_st == 0) px = $urandom_range(576);
            else if ($urandom_range(1) == 1) px = (m_x > 70) ? m_x - int'($urandom_range(70)) : int'($urandom_range(m_x));
            else px = $urandom_range(1023);
            cyc(r[0], t[0], l[0], bh[0], px);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
